// File: rtl/digit_scan_ctrl_pkg.sv
// =============================================================================
// Module      : digit_scan_ctrl_pkg
// Description : Shared scan-state encodings and select geometry for the
//               digit scan controller and the downstream 3-to-8 decoder.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package digit_scan_ctrl_pkg;

    localparam int SEL_W = 3;
    localparam int NPOS  = 8;

    typedef enum logic [1:0] {
        SCAN_IDLE   = 2'd0,
        SCAN_ACTIVE = 2'd1,
        SCAN_BLANK  = 2'd2
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/digit_scan_ctrl_mask_next_sel.sv
// =============================================================================
// Module      : mask_next_sel
// Description : Circular search for the first set mask bit strictly after cur;
//               wrap flags that the search passed position 7.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mask_next_sel
    import digit_scan_ctrl_pkg::*;
(
    input  logic [SEL_W-1:0] cur,
    input  logic [NPOS-1:0]  mask,
    output logic [SEL_W-1:0] nxt,
    output logic             wrap
);

    logic             w_found;
    logic [SEL_W-1:0] w_idx;

    // Offset NPOS lands back on cur, so a lone set bit selects itself.
    always_comb begin
        nxt     = cur;
        wrap    = 1'b0;
        w_found = 1'b0;
        w_idx   = cur;
        for (int k = 1; k <= NPOS; k++) begin
            w_idx = cur + SEL_W'(k);
            if (!w_found && mask[w_idx]) begin
                w_found = 1'b1;
                nxt     = w_idx;
                wrap    = (w_idx <= cur);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/digit_scan_ctrl.sv
// =============================================================================
// Module      : digit_scan_ctrl
// Description : Steps a select code through the enabled mask positions with a
//               programmable dwell per position and blanking gap between them.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module digit_scan_ctrl
    import digit_scan_ctrl_pkg::*;
#(
    parameter int DWELL_W = 16,
    parameter int BLANK_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [BLANK_W-1:0] blank,
    input  logic [NPOS-1:0]    digit_mask,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               frame_done,
    output logic               busy
);

    scan_state_t        r_state;
    scan_state_t        w_state_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic               r_sel_valid;
    logic               w_valid_nxt;
    logic               r_frame_done;
    logic               w_fd_nxt;
    logic               r_busy;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic [BLANK_W-1:0] r_blank_cnt;
    logic [BLANK_W-1:0] w_blank_nxt;

    logic [SEL_W-1:0]   w_cur;
    logic [SEL_W-1:0]   w_next_pos;
    logic               w_wrap;
    logic               w_run;
    logic [DWELL_W-1:0] w_dwell_load;

    // From IDLE, searching after position 7 yields the lowest set bit.
    assign w_cur        = (r_state == SCAN_IDLE) ? SEL_W'(NPOS - 1) : r_sel;
    assign w_run        = en && (digit_mask != '0);
    assign w_dwell_load = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

    mask_next_sel u_next (
        .cur  (w_cur),
        .mask (digit_mask),
        .nxt  (w_next_pos),
        .wrap (w_wrap)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_valid_nxt = r_sel_valid;
        w_fd_nxt    = 1'b0;
        w_dwell_nxt = r_dwell_cnt;
        w_blank_nxt = r_blank_cnt;
        case (r_state)
            SCAN_IDLE: begin
                w_valid_nxt = 1'b0;
                if (w_run) begin
                    w_state_nxt = SCAN_ACTIVE;
                    w_sel_nxt   = w_next_pos;
                    w_valid_nxt = 1'b1;
                    w_dwell_nxt = w_dwell_load;
                end
            end
            SCAN_ACTIVE: begin
                if (r_dwell_cnt != '0) begin
                    w_dwell_nxt = r_dwell_cnt - DWELL_W'(1);
                end else if (!w_run) begin
                    w_state_nxt = SCAN_IDLE;
                    w_valid_nxt = 1'b0;
                end else if (blank != '0) begin
                    w_state_nxt = SCAN_BLANK;
                    w_valid_nxt = 1'b0;
                    w_blank_nxt = blank - BLANK_W'(1);
                end else begin
                    w_sel_nxt   = w_next_pos;
                    w_fd_nxt    = w_wrap;
                    w_dwell_nxt = w_dwell_load;
                end
            end
            SCAN_BLANK: begin
                if (r_blank_cnt != '0) begin
                    w_blank_nxt = r_blank_cnt - BLANK_W'(1);
                end else if (!w_run) begin
                    w_state_nxt = SCAN_IDLE;
                end else begin
                    w_state_nxt = SCAN_ACTIVE;
                    w_sel_nxt   = w_next_pos;
                    w_valid_nxt = 1'b1;
                    w_fd_nxt    = w_wrap;
                    w_dwell_nxt = w_dwell_load;
                end
            end
            default: begin
                w_state_nxt = SCAN_IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SCAN_IDLE;
            r_sel        <= '0;
            r_sel_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
            r_dwell_cnt  <= '0;
            r_blank_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_sel_valid  <= w_valid_nxt;
            r_frame_done <= w_fd_nxt;
            r_busy       <= (w_state_nxt != SCAN_IDLE);
            r_dwell_cnt  <= w_dwell_nxt;
            r_blank_cnt  <= w_blank_nxt;
        end
    end

    assign sel        = r_sel;
    assign sel_valid  = r_sel_valid;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_digit_scan_ctrl.sv
// =============================================================================
// Module      : tb_digit_scan_ctrl
// Description : Scoreboard bench for digit_scan_ctrl; a cycle model queues the
//               expected {busy, frame_done, sel_valid, sel} per clock edge.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_digit_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] dwell;
    logic [7:0]  blank;
    logic [7:0]  digit_mask;
    logic [2:0]  sel;
    logic        sel_valid;
    logic        frame_done;
    logic        busy;
    logic [5:0]  obs;

    int ntests = 0;
    int nfail  = 0;
    logic [5:0] q[$];

    digit_scan_ctrl #(.DWELL_W(16), .BLANK_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .dwell      (dwell),
        .blank      (blank),
        .digit_mask (digit_mask),
        .sel        (sel),
        .sel_valid  (sel_valid),
        .frame_done (frame_done),
        .busy       (busy)
    );

    assign obs = {busy, frame_done, sel_valid, sel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [3:0] model_next(input logic [2:0] c, input logic [7:0] m);
        for (int k = 1; k <= 8; k++) begin
            int p;
            p = (int'(c) + k) % 8;
            if (m[p]) return {(p <= int'(c)), 3'(p)};
        end
        return {1'b0, c};
    endfunction

    // Reference model: phase 0 idle, 1 dwell, 2 gap; left = cycles remaining.
    initial begin
        int         ph;
        int         left;
        logic [2:0] ms;
        logic       mv;
        logic       mfd;
        logic [3:0] nx;
        ph = 0; left = 0; ms = 0; mv = 0; mfd = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                ph = 0; left = 0; ms = 0; mv = 0; mfd = 0;
                q.delete();
            end else begin
                mfd = 0;
                if (ph == 0) begin
                    mv = 0;
                    if (en && digit_mask != 0) begin
                        for (int i = 7; i >= 0; i--) if (digit_mask[i]) ms = 3'(i);
                        mv = 1; ph = 1;
                        left = (dwell == 0) ? 1 : int'(dwell);
                    end
                end else begin
                    left = left - 1;
                    if (left == 0) begin
                        if (!en || digit_mask == 0) begin
                            ph = 0; mv = 0;
                        end else if (ph == 1 && blank != 0) begin
                            ph = 2; mv = 0; left = int'(blank);
                        end else begin
                            nx = model_next(ms, digit_mask);
                            ms = nx[2:0]; mfd = nx[3]; mv = 1; ph = 1;
                            left = (dwell == 0) ? 1 : int'(dwell);
                        end
                    end
                end
                q.push_back({(ph != 0), mfd, mv, ms});
            end
        end
    end

    task automatic pop_exp(output logic [5:0] e);
        if (q.size() == 0) e = 'x;
        else e = q.pop_front();
    endtask

    task automatic test_reset();
        logic [5:0] e;
        rst_n = 1'b0; en = 1'b0; dwell = 16'd1; blank = 8'd0; digit_mask = 8'h00;
        repeat (2) @(negedge clk);
        if (obs !== 6'b0) begin nfail++; $display("FAIL reset_state got %b exp %b", obs, 6'b0); end
        ntests++;
        rst_n = 1'b1;
        q.delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); pop_exp(e);
            if (obs !== e) begin nfail++; $display("FAIL reset_idle cyc %0d got %b exp %b", k, obs, e); end
            ntests++;
        end
    endtask

    task automatic test_two_positions();
        logic [5:0] e;
        logic [2:0] exp_sel [9] = '{0, 0, 0, 2, 2, 2, 0, 0, 0};
        @(negedge clk); q.delete();
        digit_mask = 8'b0000_0101; dwell = 16'd3; blank = 8'd0; en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk); pop_exp(e);
            if (obs !== e) begin nfail++; $display("FAIL two_pos cyc %0d got %b exp %b", k, obs, e); end
            ntests++;
            if (k < 9) begin
                if (sel !== exp_sel[k] || sel_valid !== 1'b1 || frame_done !== (k == 6)) begin
                    nfail++;
                    $display("FAIL two_pos_seq cyc %0d got sel=%0d v=%b fd=%b exp sel=%0d v=1 fd=%b",
                             k, sel, sel_valid, frame_done, exp_sel[k], (k == 6));
                end
                ntests++;
            end
            if (k == 4) en = 1'b0;
            if (k == 5) en = 1'b1;
            if (k == 20) en = 1'b0;
        end
    endtask

    task automatic test_full_blank();
        logic [5:0] e;
        int first_fd;
        int second_fd;
        first_fd = -1; second_fd = -1;
        @(negedge clk); q.delete();
        digit_mask = 8'hFF; dwell = 16'd2; blank = 8'd1; en = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk); pop_exp(e);
            if (obs !== e) begin nfail++; $display("FAIL full_blank cyc %0d got %b exp %b", k, obs, e); end
            ntests++;
            if (frame_done === 1'b1) begin
                if (first_fd < 0) first_fd = k;
                else if (second_fd < 0) second_fd = k;
            end
        end
        if (first_fd != 24 || second_fd != 48) begin
            nfail++; $display("FAIL frame_period got fd at %0d,%0d exp 24,48", first_fd, second_fd);
        end
        ntests++;
        en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); pop_exp(e);
            if (obs !== e) begin nfail++; $display("FAIL full_blank_stop cyc %0d got %b exp %b", k, obs, e); end
            ntests++;
        end
    endtask

    task automatic test_single_bit();
        logic [5:0] e;
        int nfd;
        nfd = 0;
        @(negedge clk); q.delete();
        digit_mask = 8'b1000_0000; dwell = 16'd0; blank = 8'd0; en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); pop_exp(e);
            if (obs !== e) begin nfail++; $display("FAIL single cyc %0d got %b exp %b", k, obs, e); end
            ntests++;
            if (sel !== 3'd7) begin nfail++; $display("FAIL single_sel cyc %0d got %0d exp 7", k, sel); end
            ntests++;
            if (frame_done === 1'b1) nfd++;
        end
        if (nfd != 9) begin nfail++; $display("FAIL single_fd_count got %0d exp 9", nfd); end
        ntests++;
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); pop_exp(e);
            if (obs !== e) begin nfail++; $display("FAIL single_stop cyc %0d got %b exp %b", k, obs, e); end
            ntests++;
        end
    endtask

    task automatic test_en_drop();
        logic [5:0] e;
        @(negedge clk); q.delete();
        digit_mask = 8'hFF; dwell = 16'd4; blank = 8'd0; en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); pop_exp(e);
            if (obs !== e) begin nfail++; $display("FAIL en_drop cyc %0d got %b exp %b", k, obs, e); end
            ntests++;
            if (k == 12) en = 1'b0;
            if (k == 15 && obs !== 6'b101011) begin
                nfail++; $display("FAIL en_drop_last got %b exp %b", obs, 6'b101011);
            end
            if (k == 16 && obs !== 6'b000011) begin
                nfail++; $display("FAIL en_drop_idle got %b exp %b", obs, 6'b000011);
            end
            if (k == 15 || k == 16) ntests++;
        end
    endtask

    task automatic test_mask_change();
        logic [5:0] e;
        @(negedge clk); q.delete();
        digit_mask = 8'h0F; dwell = 16'd3; blank = 8'd0; en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); pop_exp(e);
            if (obs !== e) begin nfail++; $display("FAIL mask_chg cyc %0d got %b exp %b", k, obs, e); end
            ntests++;
            if (k == 3) digit_mask = 8'hF0;
            if (k == 5 && obs !== 6'b101001) begin
                nfail++; $display("FAIL mask_chg_hold got %b exp %b", obs, 6'b101001);
            end
            if (k == 6 && obs !== 6'b101100) begin
                nfail++; $display("FAIL mask_chg_next got %b exp %b", obs, 6'b101100);
            end
            if (k == 5 || k == 6) ntests++;
            if (k == 10) en = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        logic [5:0] e;
        @(negedge clk); q.delete();
        digit_mask = 8'hFF; dwell = 16'd2; blank = 8'd3; en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); pop_exp(e);
            if (obs !== e) begin nfail++; $display("FAIL areset_pre cyc %0d got %b exp %b", k, obs, e); end
            ntests++;
        end
        if (busy !== 1'b1 || sel_valid !== 1'b0) begin
            nfail++; $display("FAIL areset_in_blank got busy=%b v=%b exp busy=1 v=0", busy, sel_valid);
        end
        ntests++;
        #2 rst_n = 1'b0;
        #1;
        if (obs !== 6'b0) begin nfail++; $display("FAIL areset_async got %b exp %b", obs, 6'b0); end
        ntests++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); pop_exp(e);
            if (obs !== e) begin nfail++; $display("FAIL areset_post cyc %0d got %b exp %b", k, obs, e); end
            ntests++;
            if (k == 0 && obs !== 6'b101000) begin
                nfail++; $display("FAIL areset_restart got %b exp %b", obs, 6'b101000);
            end
            if (k == 0) ntests++;
        end
        en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); pop_exp(e);
            if (obs !== e) begin nfail++; $display("FAIL areset_stop cyc %0d got %b exp %b", k, obs, e); end
            ntests++;
        end
        digit_mask = 8'h00; en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); pop_exp(e);
            if (obs !== e) begin nfail++; $display("FAIL zero_mask cyc %0d got %b exp %b", k, obs, e); end
            ntests++;
            if (busy !== 1'b0) begin nfail++; $display("FAIL zero_mask_busy cyc %0d got %b exp 0", k, busy); end
            ntests++;
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_two_positions();
        test_full_blank();
        test_single_bit();
        test_en_drop();
        test_mask_change();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

`default_nettype wire
